vect_hazard_ctrl: RTL and testbench
===================================

// Module: vect_hazard_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage SIMD pipeline (F,D,E,M,W), whose stages are separated by pipe_vect registers.
//  Tracks in-flight vector register writes in a 3-entry scoreboard (E,M,W), detects RAW hazards at decode,
//  and handles taken branches resolved in E and multi-cycle vector memory ops in M.
//  Drives stage enables, bubbles and flushes. Provides a stall performance counter and a memory-timeout flag.
// PARAMETERS
//  REG_IDX_W    4    width of vector register index (16 vregs)
//  CNT_W        16   width of stall performance counter
//  MEM_TIMEOUT  64   cycles of unacked mem_req_m before mem_err sets
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-high
//  d_valid    in   1          valid instruction in D
//  d_src1     in   REG_IDX_W  D source vreg 1
//  d_src1_rd  in   1          D reads src1
//  d_src2     in   REG_IDX_W  D source vreg 2
//  d_src2_rd  in   1          D reads src2
//  d_dst      in   REG_IDX_W  D destination vreg
//  d_wr       in   1          D writes a vreg
//  br_taken_e in   1          taken branch resolved in E this cycle
//  mem_req_m  in   1          M holds a vector memory op
//  mem_ack    in   1          memory completes the M op this cycle
//  stall_f    out  1          hold the PC and F/D register
//  stall_d    out  1          hold the D/E input (D instruction re-presented)
//  bubble_e   out  1          load a NOP into the D/E register
//  flush_d    out  1          clear the F/D register (kill fetched instruction)
//  hold_m     out  1          freeze the E/M register and E; W receives a bubble
//  stall_cnt  out  CNT_W      saturating count of cycles with stall_d=1
//  mem_err    out  1          sticky: memory op exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset: scoreboard entries invalid; stall_cnt=0; wait counter=0; mem_err=0.
//   With d_valid=br_taken_e=mem_req_m=0, all control outputs are 0.
//  Scoreboard: sb_e/sb_m/sb_w, each {valid, dst}. Control outputs are combinational from scoreboard and inputs.
//  mem_wait = mem_req_m & ~mem_ack.
//  raw = d_valid & ((d_src1_rd & hit(d_src1)) | (d_src2_rd & hit(d_src2))).
//   hit(r) = (sb_e.valid & sb_e.dst==r) | (sb_m.valid & sb_m.dst==r).
//   The W entry never causes a hit: the register file is write-first.
//  Priority, evaluated each cycle:
//   1 mem_wait: stall_f=stall_d=hold_m=1, bubble_e=flush_d=0.
//     br_taken_e is ignored; the branch stays frozen in E and is re-presented.
//     Scoreboard: sb_e and sb_m hold, sb_w<=invalid.
//   2 br_taken_e: flush_d=1, bubble_e=1, stalls=0.
//     Shift: sb_w<=sb_m, sb_m<=sb_e, sb_e<=invalid.
//   3 raw: stall_f=stall_d=1, bubble_e=1.
//     Shift as in 2, with sb_e<=invalid.
//   4 issue: all outputs 0.
//     Shift, with sb_e<={d_valid&d_wr, d_dst}.
//  Latency: a producer in E stalls a dependent instruction in D for 2 cycles; a producer in M stalls it for 1 cycle.
//  stall_cnt: +1 on each cycle with stall_d=1; saturates at all-ones and does not wrap.
//  Wait counter:
//   - increments while mem_wait=1.
//   - clears when mem_wait=0.
//   - when it reaches MEM_TIMEOUT-1 while still waiting, mem_err<=1.
//   - mem_err is sticky; only reset clears it.
//   - the counter saturates at MEM_TIMEOUT-1.
//   - pipeline control is unaffected by mem_err; the block stays in hold until ack.
//  mem_ack arriving in the first cycle of mem_req_m gives no stall (mem_wait=0).
//  Async reset mid-stall: all state clears immediately and outputs drop to the idle values.
// TESTING
//  T1 reset:
//   - assert reset mid-raw-stall.
//   - require stall_f=stall_d=bubble_e=0, stall_cnt=0, mem_err=0 while reset is high.
//  T2 RAW on E:
//   - issue v3<=.. then, next cycle, D reads src1=v3.
//   - require stall_d=1 and bubble_e=1 for 2 cycles, then issue.
//   - require stall_cnt=2.
//  T3 RAW on M / W:
//   - producer of v5 followed by 1 independent instruction, then a reader of v5: 1 stall cycle.
//   - producer followed by 2 independent instructions, then the reader: 0 stalls.
//  T4 branch:
//   - br_taken_e=1 with a raw hazard also present.
//   - require flush_d=1, bubble_e=1, stall_d=0; the following cycle sb_e is invalid.
//  T5 memory wait:
//   - mem_req_m=1 with ack after 3 cycles, and br_taken_e=1 during the wait.
//   - require hold_m=stall_f=1 for 3 cycles, flush_d=0 during the wait, flush_d=1 in the ack cycle.
//  T6 timeout/saturation:
//   - hold mem_req_m=1 with no ack.
//   - require mem_err=1 after 64 cycles, still 1 after ack.
//   - separately, stall past 2^CNT_W-1 cycles: require stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/vect_hazard_ctrl.sv
// vect_hazard_ctrl: hazard/stall/flush control for the 5-stage SIMD pipeline (F,D,E,M,W)
//   clk, reset (async, active-high)
//   d_*        : decode-stage instruction (valid, two sources with read flags, destination with write flag)
//   br_taken_e : taken branch resolved in E
//   mem_req_m  : vector memory op in M, mem_ack completes it
//   stall_f/stall_d/bubble_e/flush_d/hold_m : stage controls
//   stall_cnt  : saturating count of stall_d cycles
//   mem_err    : sticky memory-timeout flag
module vect_hazard_ctrl #(
  parameter int REG_IDX_W   = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [REG_IDX_W-1:0] d_src1,
  input  logic                 d_src1_rd,
  input  logic [REG_IDX_W-1:0] d_src2,
  input  logic                 d_src2_rd,
  input  logic [REG_IDX_W-1:0] d_dst,
  input  logic                 d_wr,
  input  logic                 br_taken_e,
  input  logic                 mem_req_m,
  input  logic                 mem_ack,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 bubble_e,
  output logic                 flush_d,
  output logic                 hold_m,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 mem_err
);
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dst;
  } sb_t;
  // Only the E and M entries are stored: the register file is write-first, so
  // an instruction in W can never cause a hit and retiring from M simply drops it.
  sb_t sb_e, sb_m;
  logic [WAIT_W-1:0] wait_cnt;
  logic mem_wait, hit1, hit2, raw, br;
  assign mem_wait = mem_req_m & ~mem_ack;
  assign hit1 = (sb_e.valid && sb_e.dst == d_src1) || (sb_m.valid && sb_m.dst == d_src1);
  assign hit2 = (sb_e.valid && sb_e.dst == d_src2) || (sb_m.valid && sb_m.dst == d_src2);
  assign raw = d_valid & ((d_src1_rd & hit1) | (d_src2_rd & hit2));
  // A branch frozen in E by a memory wait is ignored until the wait ends.
  assign br = br_taken_e & ~mem_wait;
  always_comb begin
    stall_f  = mem_wait | (~br & raw);
    stall_d  = stall_f;
    hold_m   = mem_wait;
    bubble_e = ~mem_wait & (br | raw);
    flush_d  = br;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_e      <= '0;
      sb_m      <= '0;
      stall_cnt <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
    end else begin
      if (!mem_wait) begin
        sb_m <= sb_e;
        sb_e <= (br || raw) ? '0 : sb_t'{d_valid & d_wr, d_dst};
      end
      if (stall_d && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (!mem_wait) wait_cnt <= '0;
      else if (wait_cnt == WAIT_MAX) mem_err <= 1'b1;
      else wait_cnt <= wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_vect_hazard_ctrl.sv
// tb_vect_hazard_ctrl: directed self-checking bench for vect_hazard_ctrl
module tb_vect_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic d_valid = 0, d_src1_rd = 0, d_src2_rd = 0, d_wr = 0;
  logic [3:0] d_src1 = 0, d_src2 = 0, d_dst = 0;
  logic br_taken_e = 0, mem_req_m = 0, mem_ack = 0;
  logic stall_f, stall_d, bubble_e, flush_d, hold_m, mem_err;
  logic [15:0] stall_cnt;
  int n_cmp = 0, n_err = 0;
  vect_hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_src1(d_src1), .d_src1_rd(d_src1_rd),
    .d_src2(d_src2), .d_src2_rd(d_src2_rd), .d_dst(d_dst), .d_wr(d_wr),
    .br_taken_e(br_taken_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .flush_d(flush_d),
    .hold_m(hold_m), .stall_cnt(stall_cnt), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [3:0] s1, input logic r1,
                     input logic [3:0] s2, input logic r2, input logic [3:0] dst, input logic wr);
    d_valid = v; d_src1 = s1; d_src1_rd = r1; d_src2 = s2; d_src2_rd = r2; d_dst = dst; d_wr = wr;
    #1;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    tick(); tick();
    chk("reset_idle", {stall_f, stall_d, bubble_e, flush_d, hold_m, mem_err}, 6'b0);
    chk("reset_cnt", stall_cnt, 0);
    reset = 1'b0;
    // T1: reset in the middle of a RAW stall
    drv(1, 0, 0, 0, 0, 3, 1); tick();
    drv(1, 3, 1, 0, 0, 0, 0);
    chk("t1_stall_pre", stall_d, 1);
    tick();
    chk("t1_cnt_pre", stall_cnt, 1);
    reset = 1'b1; #1;
    chk("t1_rst_ctl", {stall_f, stall_d, bubble_e}, 3'b0);
    chk("t1_rst_cnt", stall_cnt, 0);
    chk("t1_rst_err", mem_err, 0);
    tick();
    chk("t1_rst_hold", {stall_f, stall_d, bubble_e, stall_cnt}, 0);
    reset = 1'b0; idle(); tick();
    // T2: producer in E stalls reader for 2 cycles
    drv(1, 0, 0, 0, 0, 3, 1);
    chk("t2_issue", {stall_d, bubble_e}, 2'b00);
    tick();
    drv(1, 3, 1, 0, 0, 0, 0);
    chk("t2_s1", {stall_f, stall_d, bubble_e}, 3'b111);
    tick();
    chk("t2_s2", {stall_f, stall_d, bubble_e}, 3'b111);
    tick();
    chk("t2_go", {stall_f, stall_d, bubble_e}, 3'b000);
    chk("t2_cnt", stall_cnt, 2);
    tick(); idle(); tick(); tick();
    // T3a: one independent instruction between producer and reader -> 1 stall
    drv(1, 0, 0, 0, 0, 5, 1); tick();
    drv(1, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 0, 0, 5, 1, 0, 0);
    chk("t3a_s1", stall_d, 1);
    tick();
    chk("t3a_go", stall_d, 0);
    tick();
    chk("t3a_cnt", stall_cnt, 3);
    idle(); tick(); tick();
    // T3b: two independent instructions -> producer in W, no stall
    drv(1, 0, 0, 0, 0, 5, 1); tick();
    drv(1, 0, 0, 0, 0, 0, 0); tick(); tick();
    drv(1, 5, 1, 0, 0, 0, 0);
    chk("t3b_nostall", {stall_d, bubble_e}, 2'b00);
    tick(); idle(); tick(); tick();
    // T4: branch wins over RAW; the killed D instruction must not enter the scoreboard
    drv(1, 0, 0, 0, 0, 9, 1); tick();
    drv(1, 9, 1, 0, 0, 10, 1); br_taken_e = 1; #1;
    chk("t4_br", {flush_d, bubble_e, stall_d, stall_f}, 4'b1100);
    tick(); br_taken_e = 0;
    drv(1, 10, 1, 0, 0, 0, 0);
    chk("t4_sbe_inv", {stall_d, bubble_e}, 2'b00);
    drv(1, 9, 1, 0, 0, 0, 0);
    chk("t4_prod_m", stall_d, 1);
    tick(); idle(); tick(); tick();
    chk("t4_cnt", stall_cnt, 4);
    // T5: memory wait of 3 cycles with a branch frozen in E
    mem_req_m = 1; br_taken_e = 1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_wait", {hold_m, stall_f, stall_d, flush_d, bubble_e}, 5'b11100);
      tick();
    end
    mem_ack = 1; #1;
    chk("t5_ack", {hold_m, stall_f, flush_d, bubble_e}, 4'b0011);
    tick(); mem_req_m = 0; mem_ack = 0; br_taken_e = 0; #1;
    chk("t5_cnt", stall_cnt, 7);
    // immediate ack: no stall at all
    mem_req_m = 1; mem_ack = 1; #1;
    chk("t5_fast_ack", {hold_m, stall_f, stall_d}, 3'b000);
    tick(); mem_req_m = 0; mem_ack = 0; #1;
    chk("t5_fast_cnt", stall_cnt, 7);
    // T6: timeout after 64 unacked cycles, then stall_cnt saturation
    mem_req_m = 1; #1;
    for (int i = 0; i < 63; i++) tick();
    chk("t6_err_63", mem_err, 0);
    tick();
    chk("t6_err_64", mem_err, 1);
    chk("t6_hold", hold_m, 1);
    for (int i = 0; i < 65600; i++) tick();
    chk("t6_sat", stall_cnt, 16'hFFFF);
    mem_ack = 1; #1;
    chk("t6_ack_rel", hold_m, 0);
    tick(); mem_req_m = 0; mem_ack = 0; #1;
    chk("t6_err_sticky", mem_err, 1);
    chk("t6_sat_keep", stall_cnt, 16'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
